// File: rtl/bist_seq_pkg.sv
// Shared types and default tables for the BIST run sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bist_seq_pkg;

  // State encodings, kept as named constants so the waveform decode is obvious
  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_DRST_ENC  = 3'd1;
  localparam logic [2:0] ST_START_ENC = 3'd2;
  localparam logic [2:0] ST_WAIT_ENC  = 3'd3;
  localparam logic [2:0] ST_CAPT_ENC  = 3'd4;
  localparam logic [2:0] ST_FIN_ENC   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_DRST  = ST_DRST_ENC,
    ST_START = ST_START_ENC,
    ST_WAIT  = ST_WAIT_ENC,
    ST_CAPT  = ST_CAPT_ENC,
    ST_FIN   = ST_FIN_ENC
  } state_t;

  // Per-run LFSR seeds, run 0 in the LSBs
  localparam logic [15:0] DEF_SEEDS = {4'hE, 4'h9, 4'h5, 4'h1};

  // Golden MISR signatures, run 0 in the LSBs
  localparam logic [31:0] DEF_SIGS = {8'h5C, 8'h27, 8'hB1, 8'h27};

endpackage

// File: rtl/bist_run_timer.sv
// Saturating per-run wait counter; hit flags the TIMEOUT-th counted cycle.
// Latency: hit is combinational from the count register.
// Backpressure: none; load wins over en.
module bist_run_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Count enabled cycles since the last load, stopping at TIMEOUT
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && (count != CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  // The cycle being counted now is the TIMEOUT-th one
  assign hit = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bist_sequencer.sv
// Drives NUM_RUNS seeded BIST passes (reset, start, wait, capture) and aggregates pass/fail.
// Latency: per run RST_CYCLES + 1 + wait cycles + 1, plus one FIN cycle per sequence.
// Backpressure: go is ignored while busy; bist_end is only sampled while waiting.
module bist_sequencer
  import bist_seq_pkg::*;
#(
  parameter int                          NUM_RUNS   = 4,
  parameter int                          SEED_W     = 4,
  parameter int                          SIG_W      = 8,
  parameter int                          RST_CYCLES = 2,
  parameter int                          TIMEOUT    = 255,
  parameter logic [NUM_RUNS*SEED_W-1:0]  SEEDS      = DEF_SEEDS,
  parameter logic [NUM_RUNS*SIG_W-1:0]   EXP_SIGS   = DEF_SIGS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [NUM_RUNS-1:0] fail_mask,
  output logic                timeout_err,
  output logic [2:0]          run_idx,
  output logic [SIG_W-1:0]    last_sig,
  output logic                dut_reset,
  output logic [SEED_W-1:0]   lfsr_seed,
  output logic                bist_start,
  input  logic                bist_end,
  input  logic [SIG_W-1:0]    signature_in
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t              state;
  state_t              next_state;
  logic [RCW-1:0]      rst_cnt;
  logic                rst_last;
  logic                timer_hit;
  logic                last_run;
  logic                sig_bad;
  logic [2:0]          run_idx_inc;
  logic [NUM_RUNS-1:0] run_bit;
  logic [NUM_RUNS-1:0] fail_mask_nxt;

  function automatic logic [SEED_W-1:0] seed_of(input logic [2:0] idx);
    return SEED_W'(SEEDS >> (idx * SEED_W));
  endfunction

  bist_run_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (state == ST_START),
    .en    (state == ST_WAIT),
    .hit   (timer_hit)
  );

  // Per-run decode: reset phase end, last run, signature compare, updated mask
  always_comb begin
    rst_last      = (rst_cnt == RCW'(RST_CYCLES - 1));
    last_run      = (run_idx == 3'(NUM_RUNS - 1));
    run_idx_inc   = run_idx + 3'd1;
    run_bit       = NUM_RUNS'(1) << run_idx;
    sig_bad       = (signature_in != SIG_W'(EXP_SIGS >> (run_idx * SIG_W)));
    fail_mask_nxt = sig_bad ? (fail_mask | run_bit) : (fail_mask & ~run_bit);
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and state-decoded strobes
  always_comb begin
    next_state = state;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    dut_reset  = 1'b0;
    bist_start = 1'b0;
    case (state)
      ST_IDLE:  if (go) next_state = ST_DRST;
      ST_DRST: begin
        dut_reset = 1'b1;
        if (rst_last) next_state = ST_START;
      end
      ST_START: begin
        bist_start = 1'b1;
        next_state = ST_WAIT;
      end
      // bist_end takes priority over a timeout landing on the same cycle
      ST_WAIT: begin
        if (bist_end) begin
          next_state = ST_CAPT;
        end else if (timer_hit) begin
          next_state = ST_FIN;
        end
      end
      ST_CAPT:  next_state = last_run ? ST_FIN : ST_DRST;
      ST_FIN: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // Run bookkeeping, seed selection, capture and result aggregation
  always_ff @(posedge clock) begin
    if (!reset) begin
      pass        <= 1'b0;
      fail_mask   <= '0;
      timeout_err <= 1'b0;
      run_idx     <= '0;
      last_sig    <= '0;
      lfsr_seed   <= seed_of(3'd0);
      rst_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            pass        <= 1'b0;
            fail_mask   <= '0;
            timeout_err <= 1'b0;
            run_idx     <= '0;
            lfsr_seed   <= seed_of(3'd0);
            rst_cnt     <= '0;
          end
        end
        ST_DRST: rst_cnt <= rst_cnt + 1'b1;
        ST_WAIT: begin
          if (!bist_end && timer_hit) begin
            fail_mask   <= fail_mask | run_bit;
            timeout_err <= 1'b1;
            pass        <= 1'b0;
          end
        end
        ST_CAPT: begin
          last_sig  <= signature_in;
          fail_mask <= fail_mask_nxt;
          rst_cnt   <= '0;
          if (last_run) begin
            // pass is settled here so it is already valid in the done cycle
            pass <= ~|fail_mask_nxt & ~timeout_err;
          end else begin
            run_idx   <= run_idx_inc;
            lfsr_seed <= seed_of(run_idx_inc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Testbench for bist_sequencer: behavioural BIST responder plus outcome model.
module tb_bist_sequencer;

  localparam int RC = 2;
  localparam int TO = 255;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic       bist_end = 1'b0;
  logic [7:0] signature_in = 8'h00;
  logic       busy, done, pass, timeout_err, dut_reset, bist_start;
  logic [3:0] fail_mask, lfsr_seed;
  logic [2:0] run_idx;
  logic [7:0] last_sig;

  always #5 clock = ~clock;

  bist_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .go           (go),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_mask    (fail_mask),
    .timeout_err  (timeout_err),
    .run_idx      (run_idx),
    .last_sig     (last_sig),
    .dut_reset    (dut_reset),
    .lfsr_seed    (lfsr_seed),
    .bist_start   (bist_start),
    .bist_end     (bist_end),
    .signature_in (signature_in)
  );

  // Reference tables
  logic [3:0] seed_tab [4] = '{4'h1, 4'h5, 4'h9, 4'hE};
  logic [7:0] sig_tab  [4] = '{8'h27, 8'hB1, 8'h27, 8'h5C};

  // Responder configuration per run: latency (<=0 never ends), bist_end hold, signature xor
  int         lat     [4];
  int         hold    [4];
  logic [7:0] corrupt [4];
  int         epoch = 0;

  int n_assert = 0;
  int n_fail = 0;
  int starts = 0;
  int dones = 0;
  logic [7:0] model_last_sig = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural BIST top: answers each start pulse after lat cycles of WAIT
  initial begin
    int my_epoch = 0;
    int cnt_left = 0;
    int hold_left = 0;
    int cur = 0;
    int nstart = 0;
    forever begin
      @(negedge clock);
      if (epoch != my_epoch) begin
        my_epoch = epoch; cnt_left = 0; hold_left = 0; nstart = 0; bist_end = 1'b0;
      end
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) bist_end = 1'b0;
      end
      if (cnt_left > 0) begin
        cnt_left--;
        if (cnt_left == 0) begin
          bist_end = 1'b1;
          signature_in = sig_tab[cur] ^ corrupt[cur];
          hold_left = hold[cur];
        end
      end
      if (bist_start === 1'b1 && nstart < 4) begin
        cur = nstart;
        nstart++;
        cnt_left = (lat[cur] > 0) ? lat[cur] : 0;
      end
    end
  end

  // Protocol monitor: reset width, start width, seed order and seed stability
  initial begin
    int my_epoch = 0;
    int rst_w = 0;
    int st_w = 0;
    int rises = 0;
    logic prev_rst = 1'b0;
    logic prev_st = 1'b0;
    logic [3:0] run_seed = 4'h0;
    forever begin
      @(negedge clock);
      if (epoch != my_epoch) begin
        my_epoch = epoch; starts = 0; rises = 0;
      end
      if (dut_reset && !prev_rst) begin
        run_seed = seed_tab[rises % 4];
        check("seed_order", 32'(lfsr_seed), 32'(run_seed));
        rises++;
      end
      if (dut_reset) rst_w++;
      else if (prev_rst) begin
        check("dut_reset_width", rst_w, RC);
        rst_w = 0;
      end
      if (bist_start) begin
        st_w++;
        starts++;
      end else if (prev_st) begin
        check("start_width", st_w, 1);
        st_w = 0;
      end
      if (done) dones++;
      if (reset && busy && !done) check("seed_stable", 32'(lfsr_seed), 32'(run_seed));
      prev_rst = dut_reset;
      prev_st  = bist_start;
    end
  end

  task automatic set_runs(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    for (int r = 0; r < 4; r++) begin
      hold[r] = 1;
      corrupt[r] = 8'h00;
    end
  endtask

  task automatic check_reset_state();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail_mask", 32'(fail_mask), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_run_idx", 32'(run_idx), 0);
    check("rst_last_sig", 32'(last_sig), 0);
    check("rst_dut_reset", 32'(dut_reset), 0);
    check("rst_bist_start", 32'(bist_start), 0);
    check("rst_lfsr_seed", 32'(lfsr_seed), 32'(seed_tab[0]));
  endtask

  // Runs one go-to-done sequence and compares against the run-level model
  task automatic run_seq(input string tag);
    logic [3:0] m_mask = 4'h0;
    logic       m_to = 1'b0;
    logic       m_pass;
    int         m_starts = 0;
    int         m_cycles = 1;
    int         m_idx = 0;
    int         cyc = 0;
    int         d0;
    for (int r = 0; r < 4; r++) begin
      m_starts++;
      m_idx = r;
      if (lat[r] <= 0 || lat[r] > TO) begin
        m_mask[r] = 1'b1;
        m_to = 1'b1;
        m_cycles += RC + 1 + TO;
        break;
      end
      m_cycles += RC + 1 + lat[r] + 1;
      model_last_sig = sig_tab[r] ^ corrupt[r];
      if (corrupt[r] != 8'h00) m_mask[r] = 1'b1;
    end
    m_pass = (m_mask == 4'h0) && !m_to;

    epoch++;
    d0 = dones;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (busy) cyc++;
      if (done) break;
      @(negedge clock);
    end
    check({tag, "_done_seen"}, 32'(done), 1);
    check({tag, "_cycles"}, cyc, m_cycles);
    check({tag, "_pass"}, 32'(pass), 32'(m_pass));
    check({tag, "_fail_mask"}, 32'(fail_mask), 32'(m_mask));
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'(m_to));
    check({tag, "_last_sig"}, 32'(last_sig), 32'(model_last_sig));
    check({tag, "_run_idx"}, 32'(run_idx), m_idx);
    check({tag, "_starts"}, starts, m_starts);
    @(negedge clock);
    check({tag, "_done_count"}, dones - d0, 1);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    check({tag, "_pass_hold"}, 32'(pass), 32'(m_pass));
    repeat (8) @(negedge clock);
  endtask

  initial begin
    int wait_n;
    int d0;
    set_runs(10, 10, 10, 10);
    repeat (2) @(negedge clock);
    check_reset_state();
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // T1: all runs clean
    set_runs(10, 10, 10, 10);
    run_seq("t1");

    // T2: run 2 signature off by one bit
    set_runs(10, 10, 10, 10);
    corrupt[2] = 8'h01;
    run_seq("t2");

    // T3: run 1 never ends
    set_runs(10, -1, 10, 10);
    run_seq("t3");

    // T4: bist_end exactly on the last allowed cycle; stale bist_end spans run 1 DRST/START
    set_runs(10, TO, 10, 10);
    hold[0] = 5;
    run_seq("t4");

    // Randomised sequences
    for (int it = 0; it < 8; it++) begin
      for (int r = 0; r < 4; r++) begin
        lat[r] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 40));
        hold[r] = int'($urandom_range(1, 5));
        corrupt[r] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      run_seq("rnd");
    end

    // T5: go while busy is ignored, then reset aborts during run 1 WAIT
    set_runs(10, 10, 10, 10);
    epoch++;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    wait_n = 0;
    while (starts < 2 && wait_n < 200) begin
      @(negedge clock);
      wait_n++;
    end
    check("t5_second_start", starts, 2);
    repeat (2) @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    check("t5_go_ignored_idx", 32'(run_idx), 1);
    check("t5_go_ignored_rst", 32'(dut_reset), 0);
    check("t5_busy", 32'(busy), 1);
    d0 = dones;
    reset = 1'b0;
    @(negedge clock);
    check_reset_state();
    reset = 1'b1;
    model_last_sig = 8'h00;
    repeat (20) @(negedge clock);
    check("t5_no_done", dones - d0, 0);
    check("t5_idle", 32'(busy), 0);

    // Recovery after abort
    set_runs(12, 7, 3, 20);
    run_seq("t5_recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
